// File: rtl/alu_seq.sv
// alu_seq: registers operands for an external alu8, captures its result, and hands it downstream with valid/ready.
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, in_a, in_b, in_sub, in_acc : request side (in_acc=1 uses the last result as A)
//   alu_a, alu_b, alu_sub -> alu8 ; alu_sum, alu_ovf <- alu8
//   out_valid/out_ready, out_sum, out_ovf, out_zero : result side
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             out_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic op_sub;
  assign alu_a = op_a;
  assign alu_b = op_b;
  assign alu_sub = op_sub;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      op_sub <= 1'b0;
      acc <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_zero <= 1'b0;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a <= in_acc ? acc : in_a;
          op_b <= in_b;
          op_sub <= in_sub;
          in_ready <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          out_sum <= alu_sum;
          out_ovf <= alu_ovf;
          out_zero <= alu_sum == '0;
          acc <= alu_sum;
          out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq against a behavioural alu8 model.
module tb_alu_seq;
  localparam int WIDTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_sub = 1'b0, in_acc = 1'b0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_sum, out_sum;
  logic alu_sub, alu_ovf, out_valid, out_ready = 1'b1, out_ovf, out_zero;
  logic [WIDTH:0] full;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign full = alu_sub ? {1'b0, alu_a} - {1'b0, alu_b} : {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_sum = full[WIDTH-1:0];
  assign alu_ovf = full[WIDTH];
  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
    .alu_sum(alu_sum), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_zero(out_zero)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic acc, input logic [7:0] s, input logic o, input logic z);
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_acc = acc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_exec_ready"}, in_ready, 0);
    check({tag, "_exec_valid"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_sum, s);
    check({tag, "_ovf"}, out_ovf, o);
    check({tag, "_zero"}, out_zero, z);
    tick();
    check({tag, "_idle_ready"}, in_ready, 1);
    check({tag, "_idle_valid"}, out_valid, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd77;
    in_b = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_sum", out_sum, 0);
      check("rst_alu_a", alu_a, 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    do_op("add", 8'd123, 8'd8, 1'b0, 1'b0, 8'd131, 1'b0, 1'b0);
    do_op("wrap", 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0);
    do_op("subz", 8'd5, 8'd5, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    do_op("acc1", 8'd10, 8'd3, 1'b0, 1'b0, 8'd13, 1'b0, 1'b0);
    do_op("acc2", 8'd99, 8'd4, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
    do_op("borrow", 8'd99, 8'd20, 1'b1, 1'b1, 8'd245, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_a = 8'd1;
    in_b = 8'd2;
    in_sub = 1'b0;
    in_acc = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_a = 8'd50;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 3);
      check("bp_ready", in_ready, 0);
      check("bp_alu_a", alu_a, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", out_valid, 0);
    check("bp_rel_ready", in_ready, 1);
    check("bp_rel_alu_a", alu_a, 1);
    in_a = 8'd7;
    in_b = 8'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rexec_valid", out_valid, 0);
    check("rexec_ready", in_ready, 1);
    check("rexec_sum", out_sum, 0);
    tick();
    check("rexec_still_idle", out_valid, 0);
    do_op("rexec_acc", 8'd99, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
    in_a = 8'd7;
    in_b = 8'd1;
    in_acc = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("rhold_pre_valid", out_valid, 1);
    check("rhold_pre_sum", out_sum, 8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rhold_valid", out_valid, 0);
    check("rhold_sum", out_sum, 0);
    tick();
    do_op("rhold_acc", 8'd99, 8'd2, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
